// File: rtl/dram_access_sched.sv
// dram_access_sched: single owner of the shared single-port data DRAM.
// Arbitrates the pipeline MEM stage (cpu_*) against the debug/trace loader
// (dbg_*), runs each access through a small FSM and returns extended load
// data with a one-cycle ack. Sub-word stores are done as read-modify-write.
// Optional feature macro DRAM_WSTRB_EN: adds dram_wstrb byte-lane enables so
// sub-word stores become a single strobed write with no read phase.
module dram_access_sched #(
  parameter int ADDR_W = 32,
  parameter int ARB_RR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_uns,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [1:0]        dbg_size,
  input  logic              dbg_uns,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_ack,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_err,
  output logic [ADDR_W-3:0] dram_addr,
  output logic              dram_re,
  output logic              dram_we,
  output logic [31:0]       dram_wdata,
  input  logic [31:0]       dram_rdata,
`ifdef DRAM_WSTRB_EN
  output logic [3:0]        dram_wstrb,
`endif
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, CHK, RD, RWAIT, MERGE_WR, WR, ERR, RESP
  } state_t;

  state_t            state;
  logic              rr_dbg;
  logic              op_dbg;
  logic              op_we;
  logic [1:0]        op_size;
  logic              op_uns;
  logic [ADDR_W-1:0] op_addr;
  logic [31:0]       op_wdata;

  logic              grant_dbg;
  logic              size_err;
  logic              enter_resp;
  logic [31:0]       resp_data;

  // Pick the lane out of a read word and sign/zero extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic        uns,
                                               input logic [1:0]  off);
    logic [31:0] bsh;
    logic [31:0] hsh;
    logic [31:0] res;
    bsh = word >> {off, 3'b000};
    hsh = word >> {off[1], 4'b0000};
    case (size)
      2'b00:   res = uns ? {24'd0, bsh[7:0]}  : {{24{bsh[7]}}, bsh[7:0]};
      2'b01:   res = uns ? {16'd0, hsh[15:0]} : {{16{hsh[15]}}, hsh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace only the addressed byte/half of the old word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic [31:0] wdata);
    logic [4:0]  sh;
    logic [31:0] mask;
    logic [31:0] data;
    if (size == 2'b00) begin
      sh   = {off, 3'b000};
      mask = 32'h0000_00FF << sh;
      data = {24'd0, wdata[7:0]} << sh;
    end else begin
      sh   = {off[1], 4'b0000};
      mask = 32'h0000_FFFF << sh;
      data = {16'd0, wdata[15:0]} << sh;
    end
    return (old & ~mask) | data;
  endfunction

`ifdef DRAM_WSTRB_EN
  // Byte-lane enables for a strobed write.
  function automatic logic [3:0] lane_strobe(input logic [1:0] size,
                                             input logic [1:0] off);
    logic [3:0] s;
    case (size)
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = 4'b0011 << off;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Store data copied into every lane so the strobe alone picks the target.
  function automatic logic [31:0] lane_data(input logic [1:0]  size,
                                            input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction
`endif

  // Arbitration: the single requester wins; on a tie RR favours the port not served last.
  always_comb begin
    grant_dbg = 1'b0;
    if (cpu_req && dbg_req) begin
      grant_dbg = (ARB_RR != 0) ? rr_dbg : 1'b0;
    end else begin
      grant_dbg = dbg_req;
    end
  end

  // Alignment and size legality of the latched request.
  always_comb begin
    size_err = 1'b0;
    case (op_size)
      2'b01:   size_err = op_addr[0];
      2'b10:   size_err = (op_addr[1:0] != 2'b00);
      2'b11:   size_err = 1'b1;
      default: size_err = 1'b0;
    endcase
  end

  // States that hand off to RESP, and the load data that goes with them.
  always_comb begin
    enter_resp = 1'b0;
    resp_data  = '0;
    case (state)
      WR, MERGE_WR, ERR: enter_resp = 1'b1;
      RWAIT: begin
        if (!op_we) begin
          enter_resp = 1'b1;
          resp_data  = load_extract(dram_rdata, op_size, op_uns, op_addr[1:0]);
        end
      end
      default: enter_resp = 1'b0;
    endcase
  end

  assign busy = (state != IDLE);

  // Main access FSM with registered DRAM strobes and per-port responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_dbg     <= 1'b0;
      op_dbg     <= 1'b0;
      op_we      <= 1'b0;
      op_size    <= 2'b00;
      op_uns     <= 1'b0;
      op_addr    <= '0;
      op_wdata   <= '0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      cpu_err    <= 1'b0;
      dbg_ack    <= 1'b0;
      dbg_rdata  <= '0;
      dbg_err    <= 1'b0;
      dram_addr  <= '0;
      dram_re    <= 1'b0;
      dram_we    <= 1'b0;
      dram_wdata <= '0;
`ifdef DRAM_WSTRB_EN
      dram_wstrb <= 4'b0000;
`endif
    end else begin
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      cpu_err   <= 1'b0;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
      dbg_err   <= 1'b0;
      dram_re   <= 1'b0;
      dram_we   <= 1'b0;
`ifdef DRAM_WSTRB_EN
      dram_wstrb <= 4'b0000;
`endif
      case (state)
        IDLE: begin
          if (cpu_req || dbg_req) begin
            state  <= CHK;
            op_dbg <= grant_dbg;
            rr_dbg <= !grant_dbg;
            if (grant_dbg) begin
              op_we    <= dbg_we;
              op_size  <= dbg_size;
              op_uns   <= dbg_uns;
              op_addr  <= dbg_addr;
              op_wdata <= dbg_wdata;
            end else begin
              op_we    <= cpu_we;
              op_size  <= cpu_size;
              op_uns   <= cpu_uns;
              op_addr  <= cpu_addr;
              op_wdata <= cpu_wdata;
            end
          end
        end
        CHK: begin
          if (size_err) begin
            state <= ERR;
`ifdef DRAM_WSTRB_EN
          end else if (op_we) begin
            state      <= WR;
            dram_we    <= 1'b1;
            dram_addr  <= op_addr[ADDR_W-1:2];
            dram_wdata <= lane_data(op_size, op_wdata);
            dram_wstrb <= lane_strobe(op_size, op_addr[1:0]);
`else
          end else if (op_we && (op_size == 2'b10)) begin
            state      <= WR;
            dram_we    <= 1'b1;
            dram_addr  <= op_addr[ADDR_W-1:2];
            dram_wdata <= op_wdata;
`endif
          end else begin
            state     <= RD;
            dram_re   <= 1'b1;
            dram_addr <= op_addr[ADDR_W-1:2];
          end
        end
        RD: begin
          state <= RWAIT;
        end
        RWAIT: begin
          if (op_we) begin
            state      <= MERGE_WR;
            dram_we    <= 1'b1;
            dram_wdata <= store_merge(dram_rdata, op_size, op_addr[1:0], op_wdata);
          end else begin
            state <= RESP;
          end
        end
        WR, MERGE_WR, ERR: begin
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (enter_resp) begin
        if (op_dbg) begin
          dbg_ack   <= 1'b1;
          dbg_rdata <= resp_data;
          dbg_err   <= (state == ERR);
        end else begin
          cpu_ack   <= 1'b1;
          cpu_rdata <= resp_data;
          cpu_err   <= (state == ERR);
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_access_sched.sv
// Bench for dram_access_sched: a behavioural DRAM with 1-cycle read latency,
// directed steps in one initial block, and a queue of expected responses
// pushed when a request is driven and popped when an ack appears.
// A second instance with ARB_RR=0 shares the requester inputs to observe
// fixed-priority behaviour. Honours DRAM_WSTRB_EN when defined.
module tb_dram_access_sched;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_uns;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ack, cpu_err;
  logic [31:0] cpu_rdata;
  logic        dbg_req, dbg_we, dbg_uns;
  logic [1:0]  dbg_size;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_ack, dbg_err;
  logic [31:0] dbg_rdata;
  logic [29:0] dram_addr;
  logic        dram_re, dram_we;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic        busy;
`ifdef DRAM_WSTRB_EN
  logic [3:0]  dram_wstrb;
  logic [3:0]  fp_dram_wstrb;
  logic [3:0]  last_wstrb;
`endif

  logic        fp_cpu_ack, fp_cpu_err, fp_dbg_ack, fp_dbg_err;
  logic [31:0] fp_cpu_rdata, fp_dbg_rdata;
  logic [29:0] fp_dram_addr;
  logic        fp_dram_re, fp_dram_we, fp_busy;
  logic [31:0] fp_dram_wdata;
  logic [31:0] fp_dram_rdata;

  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem [0:255];

  int vectors;
  int miscompares;

  typedef struct {
    bit          port;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  dram_access_sched #(.ADDR_W(32), .ARB_RR(1)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_uns(cpu_uns),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_size(dbg_size), .dbg_uns(dbg_uns),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
    .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .dram_addr(dram_addr), .dram_re(dram_re), .dram_we(dram_we),
    .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
`ifdef DRAM_WSTRB_EN
    .dram_wstrb(dram_wstrb),
`endif
    .busy(busy)
  );

  dram_access_sched #(.ADDR_W(32), .ARB_RR(0)) u_fp (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_uns(cpu_uns),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(fp_cpu_ack),
    .cpu_rdata(fp_cpu_rdata), .cpu_err(fp_cpu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_size(dbg_size), .dbg_uns(dbg_uns),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(fp_dbg_ack),
    .dbg_rdata(fp_dbg_rdata), .dbg_err(fp_dbg_err),
    .dram_addr(fp_dram_addr), .dram_re(fp_dram_re), .dram_we(fp_dram_we),
    .dram_wdata(fp_dram_wdata), .dram_rdata(fp_dram_rdata),
`ifdef DRAM_WSTRB_EN
    .dram_wstrb(fp_dram_wstrb),
`endif
    .busy(fp_busy)
  );

  assign fp_dram_rdata = 32'h0;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural DRAM: synchronous read, word or strobed write, bench preload.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (dram_re) dram_rdata <= mem[dram_addr[7:0]];
    if (dram_we) begin
`ifdef DRAM_WSTRB_EN
      for (int i = 0; i < 4; i++)
        if (dram_wstrb[i]) mem[dram_addr[7:0]][i*8 +: 8] <= dram_wdata[i*8 +: 8];
`else
      mem[dram_addr[7:0]] <= dram_wdata;
`endif
    end
  end

  // Hard stop if something hangs beyond every per-step bound.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=hang expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] byte_addr, input logic [31:0] data);
    @(negedge clk);
    pre_en   = 1'b1;
    pre_addr = byte_addr[9:2];
    pre_data = data;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  task automatic drivePort(input bit port, input logic req, input logic we,
                           input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      dbg_req = req; dbg_we = we; dbg_size = size; dbg_uns = uns;
      dbg_addr = addr; dbg_wdata = wdata;
    end else begin
      cpu_req = req; cpu_we = we; cpu_size = size; cpu_uns = uns;
      cpu_addr = addr; cpu_wdata = wdata;
    end
  endtask

  // One request on one port; checks response, latency and DRAM strobe counts.
  task automatic applyStimulus(input string tag, input bit port, input logic we,
                               input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input int exp_lat, input int exp_re, input int exp_we);
    int   cyc;
    int   re_n;
    int   we_n;
    bit   done;
    exp_t e;
    @(negedge clk);
    drivePort(port, 1'b1, we, size, uns, addr, wdata);
    sb.push_back('{port, exp_rdata, exp_err, exp_lat});
    cyc = 0; re_n = 0; we_n = 0; done = 0;
    while (!done && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      re_n += int'(dram_re);
      we_n += int'(dram_we);
`ifdef DRAM_WSTRB_EN
      if (dram_we) last_wstrb = dram_wstrb;
`endif
      if ((port ? dbg_ack : cpu_ack) === 1'b1) begin
        e = sb.pop_front();
        checkOutput({tag, "_rdata"}, port ? dbg_rdata : cpu_rdata, e.rdata);
        checkOutput({tag, "_err"}, {31'd0, port ? dbg_err : cpu_err}, {31'd0, e.err});
        checkOutput({tag, "_lat"}, cyc, e.lat);
        checkOutput({tag, "_other_ack"}, {31'd0, port ? cpu_ack : dbg_ack}, 32'd0);
        drivePort(port, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        done = 1;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s_timeout observed=no_ack expected=ack", tag);
      drivePort(port, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      void'(sb.pop_front());
    end
    checkOutput({tag, "_re_cnt"}, re_n, exp_re);
    checkOutput({tag, "_we_cnt"}, we_n, exp_we);
  endtask

  initial begin
    int   n;
    int   cyc;
    int   fpc;
    int   fpd;
    int   we_n;
    exp_t e;
    vectors = 0;
    miscompares = 0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    drivePort(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    drivePort(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
`ifdef DRAM_WSTRB_EN
    last_wstrb = 4'b0000;
`endif
    $display("[TB] start");

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    checkOutput("rst_dbg_ack", {31'd0, dbg_ack}, 32'd0);
    checkOutput("rst_re", {31'd0, dram_re}, 32'd0);
    checkOutput("rst_we", {31'd0, dram_we}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_addr", {2'b00, dram_addr}, 32'd0);
    checkOutput("rst_wdata", dram_wdata, 32'd0);
    checkOutput("rst_rdata", cpu_rdata, 32'd0);
    rst = 1'b0;

    // Word store then word load.
    applyStimulus("sw10", 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 3, 0, 1);
    applyStimulus("lw10", 0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 4, 1, 0);

    // Byte store into a preloaded word, then loads.
    preload(32'h20, 32'h11223344);
`ifdef DRAM_WSTRB_EN
    applyStimulus("sb22", 0, 1, 2'b00, 0, 32'h22, 32'h000000AA, 32'h0, 0, 3, 0, 1);
    checkOutput("sb22_wstrb", {28'd0, last_wstrb}, 32'h4);
`else
    applyStimulus("sb22", 0, 1, 2'b00, 0, 32'h22, 32'h000000AA, 32'h0, 0, 5, 1, 1);
`endif
    applyStimulus("lw20", 0, 0, 2'b10, 0, 32'h20, 32'h0, 32'h11AA3344, 0, 4, 1, 0);
    applyStimulus("lb22", 0, 0, 2'b00, 0, 32'h22, 32'h0, 32'hFFFFFFAA, 0, 4, 1, 0);
    applyStimulus("lbu22", 1, 0, 2'b00, 1, 32'h22, 32'h0, 32'h000000AA, 0, 4, 1, 0);

    // Halfword loads with both extensions, then an upper-half store.
    preload(32'h30, 32'h80007FFF);
    applyStimulus("lh32", 0, 0, 2'b01, 0, 32'h32, 32'h0, 32'hFFFF8000, 0, 4, 1, 0);
    applyStimulus("lhu30", 0, 0, 2'b01, 1, 32'h30, 32'h0, 32'h00007FFF, 0, 4, 1, 0);
`ifdef DRAM_WSTRB_EN
    applyStimulus("sh32", 1, 1, 2'b01, 0, 32'h32, 32'hCAFE1234, 32'h0, 0, 3, 0, 1);
    checkOutput("sh32_wstrb", {28'd0, last_wstrb}, 32'hC);
`else
    applyStimulus("sh32", 1, 1, 2'b01, 0, 32'h32, 32'hCAFE1234, 32'h0, 0, 5, 1, 1);
`endif
    applyStimulus("lw30", 0, 0, 2'b10, 0, 32'h30, 32'h0, 32'h12347FFF, 0, 4, 1, 0);

    // Error cases: no DRAM access, ack three cycles after grant.
    applyStimulus("sh31_err", 0, 1, 2'b01, 0, 32'h31, 32'h5555, 32'h0, 1, 3, 0, 0);
    applyStimulus("lw02_err", 0, 0, 2'b10, 0, 32'h02, 32'h0, 32'h0, 1, 3, 0, 0);
    applyStimulus("sz11_err", 1, 0, 2'b11, 0, 32'h00, 32'h0, 32'h0, 1, 3, 0, 0);

    // Both ports held: RR alternates, fixed priority keeps serving cpu.
    @(negedge clk);
    drivePort(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    drivePort(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    sb.push_back('{1'b0, 32'hDEADBEEF, 1'b0, 0});
    sb.push_back('{1'b1, 32'h11AA3344, 1'b0, 0});
    sb.push_back('{1'b0, 32'hDEADBEEF, 1'b0, 0});
    sb.push_back('{1'b1, 32'h11AA3344, 1'b0, 0});
    n = 0; cyc = 0; fpc = 0; fpd = 0;
    while (n < 4 && cyc < 60) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      fpc += int'(fp_cpu_ack);
      fpd += int'(fp_dbg_ack);
      if (cpu_ack || dbg_ack) begin
        e = sb.pop_front();
        checkOutput("arb_port", {31'd0, dbg_ack}, {31'd0, e.port});
        checkOutput("arb_excl", {31'd0, cpu_ack & dbg_ack}, 32'd0);
        checkOutput("arb_rdata", dbg_ack ? dbg_rdata : cpu_rdata, e.rdata);
        n++;
        if (n == 4) begin
          drivePort(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
          drivePort(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        end
      end
    end
    drivePort(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    drivePort(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    sb.delete();
    checkOutput("arb_count", n, 4);
    checkOutput("fp_cpu_acks", fpc, 4);
    checkOutput("fp_dbg_acks", fpd, 0);

    // Reset while the read phase of an access is pending in RWAIT.
    preload(32'h40, 32'h55667788);
    @(negedge clk);
`ifdef DRAM_WSTRB_EN
    drivePort(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h41, 32'h000000EE);
`else
    drivePort(0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h41, 32'h000000EE);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("abort_busy_before", {31'd0, busy}, 32'd1);
    we_n = int'(dram_we);
    rst = 1'b1;
    drivePort(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_addr", {2'b00, dram_addr}, 32'd0);
    checkOutput("abort_wdata", dram_wdata, 32'd0);
    repeat (2) begin
      @(negedge clk);
      we_n += int'(dram_we);
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      we_n += int'(dram_we);
    end
    checkOutput("abort_no_we", we_n, 0);
    applyStimulus("lw40", 0, 0, 2'b10, 0, 32'h40, 32'h0, 32'h55667788, 0, 4, 1, 0);
    applyStimulus("lbu41", 0, 0, 2'b00, 1, 32'h41, 32'h0, 32'h00000077, 0, 4, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
